video_in_pack: RTL

- Upstream neighbour of the video store stage; sits between the camera pixel interface and the store's wishbone-master write engine.
- Captures one 8-bit pixel per accepted cycle, packs 4 pixels into a 32-bit word, and buffers words in an internal show-ahead FIFO.
- Exposes FIFO head (data_fifo), pop strobe (r_ack) and pack-ready flag (nb_pack_available).
- Resynchronises to a fresh frame whenever the store announces a new image address (new_addr).

---
 rtl/video_in_pack_if.sv | 24 ++
 rtl/video_in_pack.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/video_in_pack_if.sv
// video_in_pack_if: camera pixel inputs and store-side FIFO signals (drop_count with VIDEO_IN_PACK_DROP_CNT_EN)
interface video_in_pack_if;
    logic [7:0]  pixel_in;
    logic        line_valid;
    logic        frame_valid;
    logic        new_addr;
    logic        r_ack;
    logic [31:0] data_fifo;
    logic        nb_pack_available;
    logic        fifo_overflow;
    logic        frame_err;
`ifdef VIDEO_IN_PACK_DROP_CNT_EN
    logic [15:0] drop_count;
    modport master (output pixel_in, line_valid, frame_valid, new_addr, r_ack,
                    input data_fifo, nb_pack_available, fifo_overflow, frame_err, drop_count);
    modport slave (input pixel_in, line_valid, frame_valid, new_addr, r_ack,
                   output data_fifo, nb_pack_available, fifo_overflow, frame_err, drop_count);
`else
    modport master (output pixel_in, line_valid, frame_valid, new_addr, r_ack,
                    input data_fifo, nb_pack_available, fifo_overflow, frame_err);
    modport slave (input pixel_in, line_valid, frame_valid, new_addr, r_ack,
                   output data_fifo, nb_pack_available, fifo_overflow, frame_err);
`endif
endinterface

// File: rtl/video_in_pack.sv
// video_in_pack: packs 8-bit camera pixels into 32-bit words in a show-ahead FIFO (drop_count with VIDEO_IN_PACK_DROP_CNT_EN)
module video_in_pack #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int NB_PACK = 16,
    parameter int DEPTH   = 64
) (
    input logic clk,
    input logic nRST,
    video_in_pack_if.slave vif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [19:0] TOTAL = 20'(WIDTH * HEIGHT);
    localparam logic [19:0] WORDS = 20'(WIDTH * HEIGHT / 4);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PACK_W = (AW + 1)'(NB_PACK / 4);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, PAD} state_t;

    state_t        state_q, state_d;
    logic          fv_q;
    logic [19:0]   pix_q, pix_d, word_q, word_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   pack_q, pack_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fill_q, fill_d;
    logic          nb_q;
    logic          sof, acc, pop, can_push, pad_push, push, drop;

    assign sof      = vif.frame_valid & ~fv_q;
    assign pop      = vif.r_ack & (fill_q != '0);
    assign can_push = (fill_q < FULL) | pop;
    assign push     = (pend_q | pad_push) & can_push;
    assign drop     = pend_q & ~can_push;
    assign fill_d   = vif.new_addr ? '0 : fill_q + (AW + 1)'(push) - (AW + 1)'(pop);

    // Capture FSM, packer and frame bookkeeping; new_addr overrides everything
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        word_d   = word_q;
        byte_d   = byte_q;
        pack_d   = pack_q;
        pend_d   = 1'b0;
        err_d    = err_q;
        ovf_d    = ovf_q | drop;
        acc      = 1'b0;
        pad_push = 1'b0;
        case (state_q)
            WAIT_SOF: if (sof) begin
                state_d = CAPTURE;
                acc     = vif.line_valid;
            end
            CAPTURE: if (!vif.frame_valid) begin
                err_d   = 1'b1;
                state_d = PAD;
                byte_d  = 2'd0;
            end else begin
                acc = vif.line_valid;
            end
            PAD: if (word_q >= WORDS) state_d = IDLE;
                 else pad_push = can_push;
            default: ;
        endcase
        if (acc) begin
            pack_d[{byte_q, 3'b000} +: 8] = vif.pixel_in;
            byte_d = byte_q + 2'd1;
            pend_d = (byte_q == 2'd3);
            pix_d  = pix_q + 20'd1;
            if (pix_d == TOTAL) state_d = IDLE;
        end
        if (pend_q | pad_push) word_d = word_q + 20'd1;
        if (vif.new_addr) begin
            state_d = WAIT_SOF;
            pix_d   = '0;
            word_d  = '0;
            byte_d  = 2'd0;
            pend_d  = 1'b0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    // Capture-side state registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fv_q    <= 1'b0;
            pix_q   <= '0;
            word_q  <= '0;
            byte_q  <= 2'd0;
            pack_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fv_q    <= vif.frame_valid;
            pix_q   <= pix_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            pack_q  <= pack_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO pointers, fill level and registered pack-ready flag
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            nb_q   <= 1'b0;
        end else begin
            wr_q   <= vif.new_addr ? '0 : wr_q + AW'(push);
            rd_q   <= vif.new_addr ? '0 : rd_q + AW'(pop);
            fill_q <= fill_d;
            nb_q   <= fill_d >= PACK_W;
        end
    end

    // FIFO storage; pad words are zero
    always_ff @(posedge clk) begin
        if (push & ~vif.new_addr) mem[wr_q] <= pad_push ? 32'h0 : pack_q;
    end

    assign vif.data_fifo         = (fill_q == '0) ? 32'h0 : mem[rd_q];
    assign vif.nb_pack_available = nb_q;
    assign vif.fifo_overflow     = ovf_q;
    assign vif.frame_err         = err_q;

`ifdef VIDEO_IN_PACK_DROP_CNT_EN
    logic [15:0] dcnt_q;

    // Saturating count of dropped words
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) dcnt_q <= '0;
        else if (vif.new_addr) dcnt_q <= '0;
        else if (drop & ~&dcnt_q) dcnt_q <= dcnt_q + 16'd1;
    end

    assign vif.drop_count = dcnt_q;
`endif
endmodule
